// File: rtl/sync_fifowr_ctrl_if.sv
// Write-side bundle of the synchronous FIFO. Master is the producer/read-side
// environment; slave is the write controller itself.
interface sync_fifowr_ctrl_if #(
    parameter int AW = 3
);
    logic          wfifo_i;
    logic          flush_i;
    logic          ovf_clr_i;
    logic [AW:0]   rptr_i;
    logic          ren_i;
    logic          wen_o;
    logic [AW-1:0] waddr_o;
    logic [AW:0]   wptr_o;
    logic          wfull_o;
    logic          ovf_o;
    logic [AW:0]   level_o;
    logic          afull_o;

    modport master (
        output wfifo_i, flush_i, ovf_clr_i, rptr_i, ren_i,
        input  wen_o, waddr_o, wptr_o, wfull_o, ovf_o, level_o, afull_o
    );

    modport slave (
        input  wfifo_i, flush_i, ovf_clr_i, rptr_i, ren_i,
        output wen_o, waddr_o, wptr_o, wfull_o, ovf_o, level_o, afull_o
    );
endinterface

// File: rtl/sync_fifowr_ctrl.sv
// Write controller for the single-clock FIFO: write gating, pointers, full/overflow,
// flush. Define SYNC_FIFOWR_LEVEL_EN to add the fill level and almost-full flag.
module sync_fifowr_ctrl #(
    parameter int AW       = 3,
    parameter int AFULL_TH = 6
) (
    input  logic              rclk,
    input  logic              rst_n,
    sync_fifowr_ctrl_if.slave bus
);
    localparam logic [AW:0] AFULL_TH_C = (AW+1)'(AFULL_TH);

    logic [AW:0] wptr_r;
    logic        wfull_r;
    logic        ovf_r;
    logic [AW:0] nxt_rptr_s;
    logic [AW:0] nxt_wptr_s;
    logic [AW:0] full_cmp_s;
    logic        wen_s;
    logic        ovf_set_s;

    // The read side's pointer after this edge keeps full exact on simultaneous read+write.
    assign nxt_rptr_s = bus.rptr_i + {{AW{1'b0}}, bus.ren_i};
    assign full_cmp_s = {~nxt_rptr_s[AW], nxt_rptr_s[AW-1:0]};
    assign wen_s      = bus.wfifo_i & ~wfull_r & ~bus.flush_i;
    assign ovf_set_s  = bus.wfifo_i & wfull_r & ~bus.flush_i;

    // Next write pointer: flush snaps it onto the read pointer, otherwise advance on accept.
    always_comb begin
        nxt_wptr_s = wptr_r;
        if (bus.flush_i) begin
            nxt_wptr_s = nxt_rptr_s;
        end else begin
            nxt_wptr_s = wptr_r + {{AW{1'b0}}, wen_s};
        end
    end

    // Pointer, full and sticky overflow state.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {(AW+1){1'b0}};
            wfull_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            wptr_r  <= nxt_wptr_s;
            wfull_r <= (nxt_wptr_s == full_cmp_s);
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (bus.ovf_clr_i) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign bus.wen_o   = wen_s;
    assign bus.waddr_o = wptr_r[AW-1:0];
    assign bus.wptr_o  = wptr_r;
    assign bus.wfull_o = wfull_r;
    assign bus.ovf_o   = ovf_r;

`ifdef SYNC_FIFOWR_LEVEL_EN
    logic [AW:0] nxt_level_s;
    logic [AW:0] level_r;
    logic        afull_r;

    assign nxt_level_s = nxt_wptr_s - nxt_rptr_s;

    // Registered fill level and almost-full flag.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= {(AW+1){1'b0}};
            afull_r <= 1'b0;
        end else begin
            level_r <= nxt_level_s;
            afull_r <= (nxt_level_s >= AFULL_TH_C);
        end
    end

    assign bus.level_o = level_r;
    assign bus.afull_o = afull_r;
`else
    logic unused_th_s;

    assign unused_th_s = ^AFULL_TH_C;
    assign bus.level_o = {(AW+1){1'b0}};
    assign bus.afull_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifowr_ctrl.sv
// Directed, table-driven bench for sync_fifowr_ctrl (AW=3, AFULL_TH=6).
module tb_sync_fifowr_ctrl;
`ifdef SYNC_FIFOWR_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    typedef struct {
        logic       wfifo;
        logic       flush;
        logic       ovf_clr;
        logic       ren;
        logic [3:0] rptr;
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wptr;
        logic       wfull;
        logic       ovf;
        logic [3:0] level;
        logic       afull;
    } vec_t;

    logic rclk;
    logic rst_n;
    int   checks;
    int   errors;

    sync_fifowr_ctrl_if #(.AW(3)) bus ();

    sync_fifowr_ctrl #(.AW(3), .AFULL_TH(6)) dut (
        .rclk  (rclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    function automatic vec_t mk(logic wfifo, logic flush, logic ovf_clr, logic ren,
                                logic [3:0] rptr, logic wen, logic [2:0] waddr,
                                logic [3:0] wptr, logic wfull, logic ovf,
                                logic [3:0] level, logic afull);
        vec_t v;
        v.wfifo = wfifo; v.flush = flush; v.ovf_clr = ovf_clr; v.ren = ren;
        v.rptr = rptr; v.wen = wen; v.waddr = waddr; v.wptr = wptr;
        v.wfull = wfull; v.ovf = ovf; v.level = level; v.afull = afull;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one vector: check combinational write strobe/address, then registered state after the edge.
    task automatic step(input vec_t v, input string tag);
        bus.wfifo_i   = v.wfifo;
        bus.flush_i   = v.flush;
        bus.ovf_clr_i = v.ovf_clr;
        bus.ren_i     = v.ren;
        bus.rptr_i    = v.rptr;
        #1;
        chk({tag, ".wen"},   {31'd0, bus.wen_o},   {31'd0, v.wen});
        chk({tag, ".waddr"}, {29'd0, bus.waddr_o}, {29'd0, v.waddr});
        @(posedge rclk);
        #1;
        chk({tag, ".wptr"},  {28'd0, bus.wptr_o},  {28'd0, v.wptr});
        chk({tag, ".wfull"}, {31'd0, bus.wfull_o}, {31'd0, v.wfull});
        chk({tag, ".ovf"},   {31'd0, bus.ovf_o},   {31'd0, v.ovf});
        chk({tag, ".level"}, {28'd0, bus.level_o}, LVL_EN ? {28'd0, v.level} : 32'd0);
        chk({tag, ".afull"}, {31'd0, bus.afull_o}, LVL_EN ? {31'd0, v.afull} : 32'd0);
    endtask

    task automatic idle_inputs();
        bus.wfifo_i   = 1'b0;
        bus.flush_i   = 1'b0;
        bus.ovf_clr_i = 1'b0;
        bus.ren_i     = 1'b0;
        bus.rptr_i    = 4'd0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".wptr"},  {28'd0, bus.wptr_o},  32'd0);
        chk({tag, ".wfull"}, {31'd0, bus.wfull_o}, 32'd0);
        chk({tag, ".ovf"},   {31'd0, bus.ovf_o},   32'd0);
        chk({tag, ".level"}, {28'd0, bus.level_o}, 32'd0);
        chk({tag, ".afull"}, {31'd0, bus.afull_o}, 32'd0);
        chk({tag, ".wen"},   {31'd0, bus.wen_o},   32'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_state("rst");
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        rst_n = 1'b1;
        @(posedge rclk);
        #1;
    endtask

    vec_t       vecs[$];
    logic [3:0] w;
    logic [3:0] r;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();

        // Fill, overflow, clear, read-while-full, set-beats-clear.
        for (int i = 0; i < 8; i++) begin
            w = 4'(i);
            vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, w[2:0], w + 4'd1,
                              (i == 7), 1'b0, w + 4'd1, (w + 4'd1) >= 4'd6));
        end
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd8, 1'b1, 1'b1, 4'd8, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd8, 1'b1, 1'b1, 4'd8, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 4'd8, 1'b1, 1'b0, 4'd8, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 3'd0, 4'd8, 1'b0, 1'b1, 4'd7, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 3'd0, 4'd9, 1'b1, 1'b1, 4'd8, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 3'd1, 4'd9, 1'b1, 1'b0, 4'd8, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 3'd1, 4'd9, 1'b1, 1'b1, 4'd8, 1'b1));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("tbl%0d", i));
        end

        // Asynchronous reset from a full, overflowed state, checked before any clock edge.
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst_full");
        @(negedge rclk);
        rst_n = 1'b1;
        @(posedge rclk);
        #1;

        // Fill to 5, then 20 cycles of write+read across the pointer wrap.
        do_reset();
        w = 4'd0;
        for (int i = 0; i < 5; i++) begin
            step(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, w[2:0], w + 4'd1, 1'b0, 1'b0,
                    w + 4'd1, (w + 4'd1) >= 4'd6), "fill5");
            w = w + 4'd1;
        end
        r = 4'd0;
        for (int i = 0; i < 20; i++) begin
            step(mk(1'b1, 1'b0, 1'b0, 1'b1, r, 1'b1, w[2:0], w + 4'd1, 1'b0, 1'b0,
                    4'd5, 1'b0), $sformatf("steady%0d", i));
            w = w + 4'd1;
            r = r + 4'd1;
        end

        // Fill to 7 with rptr=2/wptr=9, then flush during a read.
        do_reset();
        w = 4'd0;
        for (int i = 0; i < 7; i++) begin
            step(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, w[2:0], w + 4'd1, 1'b0, 1'b0,
                    w + 4'd1, (w + 4'd1) >= 4'd6), "fill7");
            w = w + 4'd1;
        end
        step(mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 3'd7, 4'd8, 1'b0, 1'b0, 4'd7, 1'b1), "rw_a");
        step(mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 3'd0, 4'd9, 1'b0, 1'b0, 4'd7, 1'b1), "rw_b");
        step(mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 3'd1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0), "flush");
        step(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 3'd3, 4'd4, 1'b0, 1'b0, 4'd1, 1'b0), "post_flush");

        // Reset asserted mid-fill at wptr=5.
        do_reset();
        w = 4'd0;
        for (int i = 0; i < 5; i++) begin
            step(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, w[2:0], w + 4'd1, 1'b0, 1'b0,
                    w + 4'd1, (w + 4'd1) >= 4'd6), "midfill");
            w = w + 4'd1;
        end
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst_mid");
        @(negedge rclk);
        rst_n = 1'b1;
        @(posedge rclk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
